pop_sample_feeder: RTL

Per-channel sample source that answers the `pop`/`ack` request protocol driven by `ringbuffered_resampler` on its input side. An upstream producer, such as an audio receiver, pushes 24-bit samples tagged with a channel number into per-channel FIFOs. When the resampler pulses `pop_o[ch]`, this block returns one sample on that channel's lane of a shared data bus and pulses `ack[ch]`. It replaces the hand-written pop/ack responders used in benches and is the production front end of the resampler.

---
 rtl/pop_sample_feeder_pkg.sv | 5 +
 rtl/pop_sample_feeder_if.sv | 13 +
 rtl/pop_sample_feeder_ram.sv | 25 ++
 rtl/pop_sample_feeder.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pop_sample_feeder_pkg.sv
// Shared sample type for the pop/ack sample feeder and the resampler bench.
package pop_sample_feeder_pkg;
    localparam int SAMPLE_W = 24;
    typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/pop_sample_feeder_if.sv
// Pop/ack/data bus between the resampler (master) and the sample feeder (slave).
interface pop_sample_feeder_if
    import pop_sample_feeder_pkg::*;
#(
    parameter int NUM_CH = 2
);
    logic [NUM_CH-1:0]          pop;
    logic [NUM_CH-1:0]          ack;
    logic [SAMPLE_W*NUM_CH-1:0] data;

    modport master (output pop, input ack, input data);
    modport slave  (input pop, output ack, output data);
endinterface

// File: rtl/pop_sample_feeder_ram.sv
// Simple dual-port sample RAM: synchronous write, synchronous read with 1-cycle latency.
module pop_sample_feeder_ram
    import pop_sample_feeder_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int WORDS  = 32
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  sample_t           wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output sample_t           rdata_o
);
    sample_t mem_q [WORDS];
    sample_t rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/pop_sample_feeder.sv
// Per-channel sample FIFOs answering the resampler pop/ack protocol.
// Define POP_SAMPLE_FEEDER_UNDERRUN_ZERO_EN to serve pops on empty channels with zero samples.
module pop_sample_feeder
    import pop_sample_feeder_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int NUM_CH_LOG2 = 1,
    parameter int DEPTH_LOG2  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en_i,
    input  logic [NUM_CH_LOG2-1:0] wr_ch_i,
    input  sample_t                wr_data_i,
    pop_sample_feeder_if.slave     bus,
    output logic [NUM_CH-1:0]      empty_o,
    output logic [NUM_CH-1:0]      full_o,
    output logic                   overflow_o,
    output logic                   underrun_o
);
    localparam int ADDR_W = NUM_CH_LOG2 + DEPTH_LOG2;
    localparam int CNT_W  = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1) << DEPTH_LOG2;

    logic [DEPTH_LOG2-1:0] wr_ptr_q [NUM_CH];
    logic [DEPTH_LOG2-1:0] wr_ptr_d [NUM_CH];
    logic [DEPTH_LOG2-1:0] rd_ptr_q [NUM_CH];
    logic [DEPTH_LOG2-1:0] rd_ptr_d [NUM_CH];
    logic [CNT_W-1:0]      count_q  [NUM_CH];
    logic [CNT_W-1:0]      count_d  [NUM_CH];
    sample_t               lane_q   [NUM_CH];
    sample_t               lane_d   [NUM_CH];
    logic [NUM_CH-1:0]     pending_q, pending_d, ack_q, ack_d;
    logic [NUM_CH-1:0]     empty_q, empty_d, full_q, full_d;
    logic                  overflow_q, overflow_d, underrun_q, underrun_d, zero_q, zero_d;

    logic [NUM_CH-1:0]      has_data, serviceable, grant_mask;
    logic                   grant_vld, grant_has_data;
    logic [NUM_CH_LOG2-1:0] grant_ch;
    logic [DEPTH_LOG2-1:0]  grant_ptr;
    logic                   ram_we;
    logic [ADDR_W-1:0]      ram_waddr;
    sample_t                ram_rdata, resp_data;
    logic [SAMPLE_W*NUM_CH-1:0] data_o;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) has_data[c] = (count_q[c] != '0);
    end

`ifdef POP_SAMPLE_FEEDER_UNDERRUN_ZERO_EN
    assign serviceable = '1;
`else
    assign serviceable = has_data;
`endif

    // Fixed-priority arbiter: lowest pending, serviceable channel wins
    always_comb begin
        grant_vld      = 1'b0;
        grant_ch       = '0;
        grant_ptr      = '0;
        grant_has_data = 1'b0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (pending_q[c] && serviceable[c]) begin
                grant_vld      = 1'b1;
                grant_ch       = NUM_CH_LOG2'(c);
                grant_ptr      = rd_ptr_q[c];
                grant_has_data = has_data[c];
            end
        end
        grant_mask = grant_vld ? (NUM_CH'(1) << grant_ch) : '0;
    end

    always_comb begin
        pending_d  = (pending_q & ~grant_mask) | (bus.pop & ~pending_q);
        ack_d      = grant_mask;
        zero_d     = grant_vld & ~grant_has_data;
        underrun_d = underrun_q | zero_d;
        overflow_d = overflow_q;
        ram_we     = 1'b0;
        ram_waddr  = '0;
        resp_data  = zero_q ? sample_t'(0) : ram_rdata;
        for (int c = 0; c < NUM_CH; c++) begin
            logic push_ok;
            logic serve;
            push_ok     = 1'b0;
            serve       = grant_mask[c] & has_data[c];
            wr_ptr_d[c] = wr_ptr_q[c];
            rd_ptr_d[c] = rd_ptr_q[c];
            if (wr_en_i && wr_ch_i == NUM_CH_LOG2'(c)) begin
                if (count_q[c] == DEPTH) begin
                    overflow_d = 1'b1;
                end else begin
                    push_ok     = 1'b1;
                    ram_we      = 1'b1;
                    ram_waddr   = {NUM_CH_LOG2'(c), wr_ptr_q[c]};
                    wr_ptr_d[c] = wr_ptr_q[c] + DEPTH_LOG2'(1);
                end
            end
            if (serve) rd_ptr_d[c] = rd_ptr_q[c] + DEPTH_LOG2'(1);
            count_d[c] = count_q[c] + CNT_W'(push_ok) - CNT_W'(serve);
            empty_d[c] = (count_d[c] == '0);
            full_d[c]  = (count_d[c] == DEPTH);
            // Lane follows the RAM output only in its ack cycle, then holds
            lane_d[c]  = ack_q[c] ? resp_data : lane_q[c];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                count_q[c]  <= '0;
                lane_q[c]   <= '0;
            end
            pending_q  <= '0;
            ack_q      <= '0;
            empty_q    <= '1;
            full_q     <= '0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                count_q[c]  <= count_d[c];
                lane_q[c]   <= lane_d[c];
            end
            pending_q  <= pending_d;
            ack_q      <= ack_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            underrun_q <= underrun_d;
            zero_q     <= zero_d;
        end
    end

    pop_sample_feeder_ram #(
        .ADDR_W (ADDR_W),
        .WORDS  (NUM_CH << DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (wr_data_i),
        .re_i    (grant_vld & grant_has_data),
        .raddr_i ({grant_ch, grant_ptr}),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) data_o[c*SAMPLE_W +: SAMPLE_W] = lane_d[c];
    end

    assign bus.ack    = ack_q;
    assign bus.data   = data_o;
    assign empty_o    = empty_q;
    assign full_o     = full_q;
    assign overflow_o = overflow_q;
    assign underrun_o = underrun_q;
endmodule
